// File: rtl/rs_pkg.sv
// Shared types and defaults for the RS latch button driver.
package rs_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SET_PULSE,
      RST_PULSE,
      LOCK
   } state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 8;
   localparam int PULSE_CYCLES_DEF    = 4;

endpackage

// File: rtl/rs_debounce.sv
// Two-flop synchroniser, debounce counter and registered rising-edge strobe
// for one raw push-button.
module rs_debounce
   import rs_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         rise  <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         rise  <= 1'b0;
         // Any agreeing cycle restarts the stability count
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync2;
            rise  <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/rs_button_driver.sv
// Debounced set/reset buttons to fixed-width S/R pulses; a simultaneous
// press locks out until both buttons are released.
module rs_button_driver
   import rs_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int PULSE_CYCLES    = PULSE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_set,
   input  logic btn_reset,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict
);

   localparam int PW = $clog2(PULSE_CYCLES + 1);
   localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);

   state_t        state;
   state_t        state_nx;
   logic [PW-1:0] pcnt;
   logic [PW-1:0] pcnt_nx;
   logic          conflict_nx;
   logic          set_level;
   logic          set_rise;
   logic          rst_level;
   logic          rst_rise;

   rs_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_set (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_set),
      .level(set_level),
      .rise (set_rise)
   );

   rs_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_db_rst (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_reset),
      .level(rst_level),
      .rise (rst_rise)
   );

   always_comb begin
      state_nx    = state;
      pcnt_nx     = pcnt;
      conflict_nx = 1'b0;
      unique case (state)
         IDLE: begin
            pcnt_nx = '0;
            if (set_rise && rst_rise) begin
               state_nx    = LOCK;
               conflict_nx = 1'b1;
            end else if (set_rise) begin
               state_nx = SET_PULSE;
            end else if (rst_rise) begin
               state_nx = RST_PULSE;
            end
         end
         SET_PULSE, RST_PULSE: begin
            // Strobes are ignored here, so presses during a pulse are dropped
            if (pcnt == PULSE_LAST) begin
               state_nx = IDLE;
               pcnt_nx  = '0;
            end else begin
               pcnt_nx = pcnt + 1'b1;
            end
         end
         LOCK: begin
            if (!set_level && !rst_level) begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
            pcnt_nx  = '0;
         end
      endcase
   end

   // Outputs are flops loaded from the next state, so S and R are glitch-free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pcnt     <= '0;
         S        <= 1'b0;
         R        <= 1'b0;
         busy     <= 1'b0;
         conflict <= 1'b0;
      end else begin
         state    <= state_nx;
         pcnt     <= pcnt_nx;
         S        <= (state_nx == SET_PULSE);
         R        <= (state_nx == RST_PULSE);
         busy     <= (state_nx != IDLE);
         conflict <= conflict_nx;
      end
   end

endmodule

// File: tb/tb_rs_button_driver.sv
// Bench for rs_button_driver: directed scenarios with literal expectations
// plus randomized buttons checked each cycle against a behavioural model.
module tb_rs_button_driver;

   localparam int D = 8;
   localparam int P = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn_set = 1'b0;
   logic btn_reset = 1'b0;
   logic S;
   logic R;
   logic busy;
   logic conflict;

   int n_checks = 0;
   int n_fail = 0;

   rs_button_driver #(
      .DEBOUNCE_CYCLES(D),
      .PULSE_CYCLES(P)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_set(btn_set),
      .btn_reset(btn_reset),
      .S(S),
      .R(R),
      .busy(busy),
      .conflict(conflict)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, int got, int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d required %0d", nm, $time, got, exp);
      end
   endfunction

   // Behavioural model: a press is accepted once the synchronised button
   // has disagreed with the accepted level for D consecutive edges.
   bit ms1[2];
   bit ms2[2];
   bit mlvl[2];
   bit mrise[2];
   int mrun[2];
   bit mraw[2];
   int mmode = 0;  // 0 idle, 1 set pulse, 2 reset pulse, 3 lockout
   int mleft = 0;
   bit mconf = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            ms1[c] = 0; ms2[c] = 0; mlvl[c] = 0;
            mrise[c] = 0; mrun[c] = 0;
         end
         mmode = 0; mleft = 0; mconf = 0;
      end else begin
         mraw[0] = btn_set;
         mraw[1] = btn_reset;
         mconf = 0;
         case (mmode)
            0: begin
               if (mrise[0] && mrise[1]) begin
                  mmode = 3; mconf = 1;
               end else if (mrise[0]) begin
                  mmode = 1; mleft = P;
               end else if (mrise[1]) begin
                  mmode = 2; mleft = P;
               end
            end
            1, 2: begin
               mleft--;
               if (mleft == 0) mmode = 0;
            end
            default: if (!mlvl[0] && !mlvl[1]) mmode = 0;
         endcase
         for (int c = 0; c < 2; c++) begin
            mrise[c] = 0;
            if (ms2[c] != mlvl[c]) begin
               mrun[c]++;
               if (mrun[c] == D) begin
                  mlvl[c] = ms2[c];
                  mrise[c] = ms2[c];
                  mrun[c] = 0;
               end
            end else begin
               mrun[c] = 0;
            end
            ms2[c] = ms1[c];
            ms1[c] = mraw[c];
         end
      end
   end

   int srun = 0;
   int rrun = 0;

   always @(negedge clk) begin
      chk("outputs_vs_model", int'({S, R, busy, conflict}),
          int'({mmode == 1, mmode == 2, mmode != 0, mconf}));
      chk("s_and_r", int'(S & R), 0);
      assert (!(S && R)) else $error("FAIL s_and_r_assert S=%b R=%b", S, R);
      if (!rst_n) begin
         srun = 0;
         rrun = 0;
      end else begin
         if (S) srun++;
         else if (srun > 0) begin
            chk("s_pulse_width", srun, P);
            srun = 0;
         end
         if (R) rrun++;
         else if (rrun > 0) begin
            chk("r_pulse_width", rrun, P);
            rrun = 0;
         end
      end
   end

   task automatic step(int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   int bad;
   int conf_cnt;
   bit e;

   initial begin
      step(3);
      chk("reset_state", int'({S, R, busy, conflict}), 0);

      // Clean set press; first sampled at edge 0
      rst_n = 1'b1;
      btn_set = 1'b1;
      for (int j = 0; j < 16; j++) begin
         step();
         e = (j >= 10 && j <= 13);
         chk("clean_set", int'({S, R, busy}), int'({e, 1'b0, e}));
      end
      btn_set = 1'b0;
      step(14);

      // Bounce rejection
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) btn_reset = ~btn_reset;
         step();
         bad += int'(R | busy);
      end
      btn_reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         bad += int'(R | busy);
      end
      chk("bounce_rejected", bad, 0);

      // Simultaneous press
      btn_set = 1'b1;
      btn_reset = 1'b1;
      conf_cnt = 0;
      bad = 0;
      for (int j = 0; j < 30; j++) begin
         step();
         conf_cnt += int'(conflict);
         bad += int'(S | R);
         if (j == 10) chk("conflict_edge10", int'(conflict), 1);
      end
      chk("lock_busy", int'(busy), 1);
      btn_set = 1'b0;
      btn_reset = 1'b0;
      for (int j = 0; j < 15; j++) begin
         step();
         bad += int'(S | R);
         if (j == 9) chk("lock_busy_until_release", int'(busy), 1);
         if (j == 10) chk("lock_exit", int'(busy), 0);
      end
      chk("conflict_count", conf_cnt, 1);
      chk("lock_no_pulse", bad, 0);

      // Reset press arriving during the S pulse is dropped
      btn_set = 1'b1;
      bad = 0;
      for (int j = 0; j < 25; j++) begin
         step();
         e = (j >= 10 && j <= 13);
         chk("press_during_pulse_S", int'(S), int'(e));
         bad += int'(R);
         if (j == 2) btn_reset = 1'b1;
      end
      chk("press_during_pulse_no_R", bad, 0);
      btn_set = 1'b0;
      btn_reset = 1'b0;
      step(14);

      // Reset mid-pulse truncates, held button re-presses after release
      btn_set = 1'b1;
      for (int j = 0; j < 12; j++) step();
      chk("mid_pulse_S_high", int'(S), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("reset_truncates", int'({S, busy}), 0);
      step();
      rst_n = 1'b1;
      for (int j = 0; j < 16; j++) begin
         step();
         e = (j >= 10 && j <= 13);
         chk("repress_after_reset", int'(S), int'(e));
      end
      btn_set = 1'b0;
      step(14);

      // Randomized buttons with occasional resets
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 11) == 0) btn_set = ~btn_set;
         if ($urandom_range(0, 11) == 0) btn_reset = ~btn_reset;
         rst_n = ($urandom_range(0, 3999) != 0);
         step();
      end
      rst_n = 1'b1;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
